audio_playback_buffer: RTL and testbench
========================================

# audio_playback_buffer

Elastic sample buffer between the processor's audio output (`audio_out` / `sample_ready`) and the PWM serializer. It absorbs the processor's bursty sample writes in a FIFO and replays them at a fixed sample rate. Each replayed 14-bit sample is converted into the 10-bit `duty_cycle` word that the PWM serializer consumes. This block replaces the single-register latch and the combinational scaling that previously fed the serializer.

## Interface
- `DEPTH`, default 16: FIFO entries; must be a power of two, at least 4.
- `SAMPLE_DIV`, default 907: `clk` cycles per output sample (40 MHz / 907 ≈ 44.1 kHz); must be at least 2.
- `PREFILL`, default 8: level at which playback starts or resumes; must satisfy 1 ≤ `PREFILL` ≤ `DEPTH`.
- `clk` in 1: system clock (40 MHz domain).
- `reset` in 1: asynchronous, active-high; clears all state.
- `sample_in` in 16: sample from the processor; unsigned, valid range 0..16383.
- `sample_ready` in 1: one-cycle write strobe qualifying `sample_in`.
- `clear_flags` in 1: synchronous clear of `overflow` and `underrun`.
- `duty_cycle` out 10: PWM duty word, 0..1023.
- `sample_tick` out 1: one-cycle pulse marking each output sample period.
- `level` out log2(DEPTH)+1: current FIFO occupancy.
- `fifo_full` out 1: `level == DEPTH`.
- `fifo_empty` out 1: `level == 0`.
- `playing` out 1: high while the FSM is in PLAY.
- `overflow` out 1: sticky; set when a write is dropped.
- `underrun` out 1: sticky; set when a tick occurs in PLAY with the FIFO empty.

## Operation
- **Tick counter:** free-running, counts 0..`SAMPLE_DIV`-1 and then wraps to 0. `sample_tick` is high exactly in the cycle where count == `SAMPLE_DIV`-1. The counter is independent of FSM state.
- **Write:**
  - When `sample_ready` is high and a slot is available, `sample_in` is stored at the write pointer and the pointer increments (wraps mod `DEPTH`).
  - A slot is available when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - If `sample_ready` is high and no slot is available, the sample is discarded and `overflow` is set.
- **Pop:** occurs on `sample_tick` in PLAY when `fifo_empty` is low. Same-cycle writes are not bypassed to the read side.
- **Scaling of a popped sample:**
  - Clamp to 16383: any value with bit 15 or bit 14 set becomes 16383.
  - Then `duty_cycle <= clamped[13:4]`, so 0 → 0 and 16383 → 1023.
- **Level:** increments on an accepted write, decrements on a pop, and is unchanged when both happen in the same cycle.
- **FSM:**
  - FILL (reset state): `duty_cycle` holds its value. Go to PLAY when `level >= PREFILL`; this is evaluated every cycle and `level` is registered.
  - PLAY: a pop occurs on each tick. A tick with `fifo_empty` high sets `underrun`, leaves `duty_cycle` unchanged (the last sample is repeated) and moves the FSM to FILL.
- **Flag priority:** `clear_flags` clears both sticky flags. A set event in the same cycle wins, so the flag reads 1 the next cycle.

## Timing
- **Reset values:**
  - `duty_cycle` = 512 (mid-scale silence).
  - `level` = 0, `fifo_empty` = 1, `fifo_full` = 0.
  - `playing` = 0, `overflow` = 0, `underrun` = 0.
  - `sample_tick` = 0, tick count = 0, both pointers = 0, FSM = FILL.
- **Reset mid-operation:** all state returns to the reset values immediately (asynchronous). FIFO contents are discarded logically.
- **Write latency:** an accepted write on cycle N appears in `level`, `fifo_empty` and `fifo_full` on cycle N+1.
- **Playback start:** the FILL→PLAY transition occurs in the cycle after `level` first reads `>= PREFILL`, so `playing` rises 1 cycle after that.
- **Pop latency:** a pop on the `sample_tick` cycle N updates `duty_cycle` and `level` on cycle N+1.
- **Underrun exit:** on an underrun tick N, `underrun` and the FILL state are visible at N+1, and `playing` drops at N+1.
- **Rate:** outputs are stable between ticks, so `duty_cycle` changes at most once per `SAMPLE_DIV` cycles.
- **Wrap-around:** pointer wrap is invisible externally. FIFO order is preserved across more than `DEPTH` total writes.

## Test plan
- **Reset and tick period:** assert `reset` for 3 cycles with `SAMPLE_DIV`=907.
  - All outputs must read their reset values.
  - The first `sample_tick` must occur exactly 906 cycles after reset deasserts, then every 907 cycles.
- **Prefill and order:** write the 8 samples 0, 16, 32, …, 112 back-to-back.
  - `playing` rises 1 cycle after `level` reads 8.
  - On successive ticks `duty_cycle` reads 0, 1, 2, …, 7.
- **Clamp and scaling:** write 16383, 16384 and 65535.
  - All three produce `duty_cycle` = 1023.
  - A write of 8191 produces 511.
- **Overflow:** write 17 samples with no ticks (`DEPTH`=16).
  - `level` = 16, `fifo_full` = 1, `overflow` = 1.
  - The 17th sample is never output.
  - Repeat with a write on a tick cycle while full: the write is accepted, `level` stays 16 and `overflow` is not set.
- **Underrun:** prefill 8 samples, let 9 ticks pass with no writes.
  - On the 9th tick `underrun` = 1, `playing` = 0 and `duty_cycle` still holds the 8th sample.
  - Writing 8 more samples resumes playback.
  - `clear_flags` then clears `underrun`.
- **Async reset mid-play:** assert `reset` between ticks while `level` = 5.
  - `level`, `duty_cycle` and `playing` must change in the same cycle, to 0, 512 and 0, with no clock edge required.

Source files
------------

// File: rtl/audio_playback_buffer.sv
// Elastic FIFO between processor audio writes and the PWM serializer, replayed at a fixed sample rate.
// Pops on each sample tick while playing; full FIFO drops writes (overflow), empty tick repeats last sample (underrun).
module audio_playback_buffer #(
    parameter int DEPTH      = 16,
    parameter int SAMPLE_DIV = 907,
    parameter int PREFILL    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              sample_in,
    input  logic                     sample_ready,
    input  logic                     clear_flags,
    output logic [9:0]               duty_cycle,
    output logic                     sample_tick,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     playing,
    output logic                     overflow,
    output logic                     underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(SAMPLE_DIV);

    typedef enum logic {FILL, PLAY} state_t;

    state_t          state;
    logic [CW-1:0]   tick_cnt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [9:0]      mem [DEPTH];

    logic            pop;
    logic            starve;
    logic            wr_en;
    logic            drop;
    logic [9:0]      wr_duty;

    assign sample_tick = (tick_cnt == CW'(SAMPLE_DIV - 1));
    assign fifo_full   = (level == LW'(DEPTH));
    assign fifo_empty  = (level == '0);
    assign playing     = (state == PLAY);

    assign pop    = sample_tick && (state == PLAY) && !fifo_empty;
    assign starve = sample_tick && (state == PLAY) && fifo_empty;
    assign wr_en  = sample_ready && (!fifo_full || pop);
    assign drop   = sample_ready && !wr_en;

    // Samples are stored already scaled; anything above 14 bits saturates to full scale.
    assign wr_duty = (sample_in[15:14] != 2'b00) ? 10'h3FF : sample_in[13:4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (sample_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_duty;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            duty_cycle <= 10'd512;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                duty_cycle <= mem[rd_ptr];
            end
            case ({wr_en, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
        end else begin
            case (state)
                FILL:    if (level >= LW'(PREFILL)) state <= PLAY;
                PLAY:    if (starve) state <= FILL;
                default: state <= FILL;
            endcase
        end
    end

    // A set event in the same cycle as clear_flags wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
            if (starve) begin
                underrun <= 1'b1;
            end else if (clear_flags) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_playback_buffer.sv
// Bench for audio_playback_buffer: queue-based reference model compared every cycle, plus directed literal checks.
module tb_audio_playback_buffer;

    localparam int DEPTH   = 16;
    localparam int DIV     = 907;
    localparam int PREFILL = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_in = '0;
    logic        sample_ready = 1'b0;
    logic        clear_flags = 1'b0;
    logic [9:0]  duty_cycle;
    logic        sample_tick;
    logic [4:0]  level;
    logic        fifo_full;
    logic        fifo_empty;
    logic        playing;
    logic        overflow;
    logic        underrun;

    int vectors = 0;
    int miscompares = 0;

    audio_playback_buffer #(.DEPTH(DEPTH), .SAMPLE_DIV(DIV), .PREFILL(PREFILL)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_ready(sample_ready),
        .clear_flags(clear_flags), .duty_cycle(duty_cycle), .sample_tick(sample_tick),
        .level(level), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .playing(playing),
        .overflow(overflow), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a queue of scaled samples plus a few flags.
    int m_q[$];
    int m_cnt;
    bit m_play, m_ovf, m_und;
    int m_duty;

    function automatic int scale(input int v);
        return (v > 16383) ? 1023 : v / 16;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_cnt  = 0;
        m_play = 0;
        m_ovf  = 0;
        m_und  = 0;
        m_duty = 512;
    endtask

    always @(posedge clk or posedge reset) begin
        bit tick, pop, starve, acc;
        int lvl;
        if (reset) begin
            model_reset();
        end else begin
            lvl    = m_q.size();
            tick   = (m_cnt == DIV - 1);
            pop    = tick && m_play && (lvl > 0);
            starve = tick && m_play && (lvl == 0);
            acc    = sample_ready && ((lvl < DEPTH) || pop);
            if (pop) m_duty = m_q.pop_front();
            if (acc) m_q.push_back(scale(int'(sample_in)));
            if (!m_play) m_play = (lvl >= PREFILL);
            else if (starve) m_play = 0;
            if (sample_ready && !acc) m_ovf = 1;
            else if (clear_flags) m_ovf = 0;
            if (starve) m_und = 1;
            else if (clear_flags) m_und = 0;
            m_cnt = (m_cnt + 1) % DIV;
        end
    end

    always @(negedge clk) begin
        chk("duty_cycle", 32'(duty_cycle), 32'(m_duty));
        chk("sample_tick", 32'(sample_tick), 32'(m_cnt == DIV - 1));
        chk("level", 32'(level), 32'(m_q.size()));
        chk("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
        chk("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
        chk("playing", 32'(playing), 32'(m_play));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underrun", 32'(underrun), 32'(m_und));
    end

    task automatic wr(input int v);
        sample_in    = 16'(v);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        while (sample_tick !== 1'b1 && n < 2 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (sample_tick !== 1'b1) chk("tick_timeout", 32'(sample_tick), 32'd1);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rv[8]  = '{16383, 16384, 65535, 8191, 160, 320, 480, 640};
        int rex[8] = '{1023, 1023, 1023, 511, 10, 20, 30, 40};
        model_reset();

        // Reset values and tick period
        repeat (3) @(negedge clk);
        chk("rst_duty", 32'(duty_cycle), 32'd512);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_playing", 32'(playing), 32'd0);
        chk("rst_flags", 32'({overflow, underrun, sample_tick}), 32'd0);
        reset = 1'b0;
        wait_tick(n);
        chk("first_tick", 32'(n), 32'd906);
        @(negedge clk);
        wait_tick(n);
        chk("tick_period", 32'(n + 1), 32'd907);
        @(negedge clk);

        // Prefill and playback order
        for (int i = 0; i < 8; i++) wr(i * 16);
        chk("prefill_level", 32'(level), 32'd8);
        chk("prefill_wait", 32'(playing), 32'd0);
        @(negedge clk);
        chk("play_start", 32'(playing), 32'd1);
        for (int k = 0; k < 8; k++) begin
            wait_tick(n);
            @(negedge clk);
            chk("order", 32'(duty_cycle), 32'(k));
        end
        wait_tick(n);
        @(negedge clk);
        chk("underrun_set", 32'(underrun), 32'd1);
        chk("underrun_stop", 32'(playing), 32'd0);
        chk("underrun_hold", 32'(duty_cycle), 32'd7);

        // Resume with clamp/scale values
        for (int i = 0; i < 8; i++) wr(rv[i]);
        @(negedge clk);
        chk("resume", 32'(playing), 32'd1);
        pulse_clear();
        chk("clear_underrun", 32'(underrun), 32'd0);
        for (int k = 0; k < 8; k++) begin
            wait_tick(n);
            @(negedge clk);
            chk("scale", 32'(duty_cycle), 32'(rex[k]));
        end
        wait_tick(n);
        @(negedge clk);
        chk("underrun_again", 32'(underrun), 32'd1);

        // Overflow, then write on a tick while full
        pulse_clear();
        for (int i = 0; i < 16; i++) wr((100 + i) * 16);
        wr(999 * 16);
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_full", 32'(fifo_full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        pulse_clear();
        chk("ovf_clear", 32'(overflow), 32'd0);
        wait_tick(n);
        wr(200 * 16);
        chk("tickwr_level", 32'(level), 32'd16);
        chk("tickwr_ovf", 32'(overflow), 32'd0);
        chk("tickwr_pop", 32'(duty_cycle), 32'd100);
        for (int k = 1; k < 16; k++) begin
            wait_tick(n);
            @(negedge clk);
            chk("ovf_order", 32'(duty_cycle), 32'(100 + k));
        end
        wait_tick(n);
        @(negedge clk);
        chk("tickwr_sample", 32'(duty_cycle), 32'd200);
        wait_tick(n);
        @(negedge clk);
        chk("dropped_never_out", 32'(duty_cycle), 32'd200);

        // Randomized traffic: a filling phase and a starving phase
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 10000; i++) begin
                sample_ready = ($urandom_range(0, (ph == 0) ? 449 : 1399) == 0);
                sample_in    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16384, 65535))
                                                           : 16'($urandom_range(0, 16383));
                clear_flags  = ($urandom_range(0, 2999) == 0);
                @(negedge clk);
            end
        end
        sample_ready = 1'b0;
        clear_flags  = 1'b0;

        // Asynchronous reset in the middle of playback
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) wr(4096 + i * 64);
        @(negedge clk);
        chk("rst2_play", 32'(playing), 32'd1);
        repeat (3) begin
            wait_tick(n);
            @(negedge clk);
        end
        chk("mid_level", 32'(level), 32'd5);
        repeat (100) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_level", 32'(level), 32'd0);
        chk("async_duty", 32'(duty_cycle), 32'd512);
        chk("async_playing", 32'(playing), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
